emmc_ddr_tx: RTL and testbench

Transmit framer for eMMC DDR (DDR52) block writes. It accepts data words from the write-data buffer over a valid/ready handshake and frames each block onto the bus as start bit, payload, per-edge CRC16 and end bit. It drives the rising-edge data, falling-edge data and output-enable inputs of the per-line IODDR cells directly. One instance serves the whole data bus.

---
 rtl/emmc_ddr_tx.sv | 195 +++++++++++++++++++
 tb/tb_emmc_ddr_tx.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/emmc_ddr_tx.sv
// emmc_ddr_tx -- eMMC DDR52 block-write transmit framer.
//
// Frames one block per start request onto the DDR data bus as:
// start bit, N payload words, 16 cycles of per-line per-edge CRC16, end bit.
// The outputs feed the per-line IODDR cells directly (rising-edge bit,
// falling-edge bit, shared output enable).
//
// Ports (emmc_ddr_tx):
//   Clk, Reset_n        card clock, async active-low reset
//   start, abort        block request / synchronous abort
//   tx_data, tx_valid,  write-data word stream; [2W-1:W] rising edge,
//   tx_ready            [W-1:0] falling edge
//   WriteData_posEdge   rising-edge bit per line
//   WriteData_negEdge   falling-edge bit per line
//   out_en, busy, done  bus drive enable, transfer active, end-of-block pulse
//   underrun            sticky missing-word flag for the current/last block
//
// emmc_ddr_crc16 is one serial CRC16 (x^16+x^12+x^5+1) for one line/edge.
// It absorbs one bit per clock while feeding, then shifts its remainder
// out MSB first while shifting.

module emmc_ddr_crc16 (
    input  logic Clk,
    input  logic Reset_n,
    input  logic clr,
    input  logic feed,
    input  logic shift,
    input  logic din,
    output logic msb
);
    logic [15:0] crc;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n)   crc <= '0;
        else if (clr)   crc <= '0;
        else if (feed)  crc <= {crc[14:0], 1'b0} ^ ((crc[15] ^ din) ? 16'h1021 : 16'h0000);
        else if (shift) crc <= {crc[14:0], 1'b0};
    end

    assign msb = crc[15];
endmodule

module emmc_ddr_tx #(
    parameter int BUS_WIDTH  = 8,
    parameter int BLOCK_SIZE = 512
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [2*BUS_WIDTH-1:0] tx_data,
    input  logic                   tx_valid,
    output logic                   tx_ready,
    output logic [BUS_WIDTH-1:0]   WriteData_posEdge,
    output logic [BUS_WIDTH-1:0]   WriteData_negEdge,
    output logic                   out_en,
    output logic                   busy,
    output logic                   done,
    output logic                   underrun
);
    localparam int N  = BLOCK_SIZE * 4 / BUS_WIDTH;
    localparam int CW = (N > 16) ? $clog2(N) : 5;
    localparam logic [CW-1:0] LAST_WORD = CW'(N - 1);
    localparam logic [CW-1:0] LAST_CRC  = CW'(15);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_CRC, S_END} state_t;

    state_t                 state, state_nx;
    logic [CW-1:0]          cnt, cnt_nx;
    logic [2*BUS_WIDTH-1:0] word_sent, crc_msb;
    logic                   crc_clr, crc_feed, crc_shift;
    logic [BUS_WIDTH-1:0]   pos_d, neg_d;
    logic                   oe_d, rdy_d, busy_d, done_d;

    // State register
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state; cnt counts words in DATA and CRC bits in CRC
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (abort && state != S_IDLE) begin
            state_nx = S_IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                S_IDLE:  if (start && !abort) state_nx = S_START;
                S_START: begin
                    state_nx = S_DATA;
                    cnt_nx   = '0;
                end
                S_DATA:
                    if (cnt == LAST_WORD) begin
                        state_nx = S_CRC;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                S_CRC:
                    if (cnt == LAST_CRC) begin
                        state_nx = S_END;
                        cnt_nx   = '0;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                S_END:   state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // A missing word is replaced by zeros so frame timing and CRC stay consistent
    assign word_sent = tx_valid ? tx_data : '0;
    assign crc_clr   = (state == S_IDLE) && start && !abort;
    assign crc_feed  = tx_ready && !abort;
    assign crc_shift = (state_nx == S_CRC);

    emmc_ddr_crc16 u_crc [2*BUS_WIDTH-1:0] (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .clr     (crc_clr),
        .feed    (crc_feed),
        .shift   (crc_shift),
        .din     (word_sent),
        .msb     (crc_msb)
    );

    // Outputs are registered, so their D values follow the state being entered
    always_comb begin
        pos_d  = '1;
        neg_d  = '1;
        oe_d   = 1'b0;
        rdy_d  = 1'b0;
        busy_d = 1'b0;
        done_d = 1'b0;
        case (state_nx)
            S_START: begin
                pos_d  = '0;
                neg_d  = '0;
                oe_d   = 1'b1;
                rdy_d  = 1'b1;
                busy_d = 1'b1;
            end
            S_DATA: begin
                pos_d  = word_sent[2*BUS_WIDTH-1:BUS_WIDTH];
                neg_d  = word_sent[BUS_WIDTH-1:0];
                oe_d   = 1'b1;
                rdy_d  = (cnt_nx != LAST_WORD);
                busy_d = 1'b1;
            end
            S_CRC: begin
                pos_d  = crc_msb[2*BUS_WIDTH-1:BUS_WIDTH];
                neg_d  = crc_msb[BUS_WIDTH-1:0];
                oe_d   = 1'b1;
                busy_d = 1'b1;
            end
            S_END: begin
                oe_d   = 1'b1;
                busy_d = 1'b1;
            end
            default: done_d = (state == S_END) && !abort;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            WriteData_posEdge <= '1;
            WriteData_negEdge <= '1;
            out_en            <= 1'b0;
            tx_ready          <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            underrun          <= 1'b0;
        end else begin
            WriteData_posEdge <= pos_d;
            WriteData_negEdge <= neg_d;
            out_en            <= oe_d;
            tx_ready          <= rdy_d;
            busy              <= busy_d;
            done              <= done_d;
            if (crc_clr)
                underrun <= 1'b0;
            else if (tx_ready && !tx_valid && !abort)
                underrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_emmc_ddr_tx.sv
// Self-checking bench for emmc_ddr_tx: one 8-bit and one 4-bit instance,
// randomized blocks compared cycle by cycle against a frame model built
// from the word list, with CRCs computed by polynomial long division.
module tb_emmc_ddr_tx;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start8, start4, abort, tx_valid;
    logic [15:0] tx_data;
    logic        rdy8, oe8, busy8, done8, ur8;
    logic [7:0]  pos8, neg8;
    logic        rdy4, oe4, busy4, done4, ur4;
    logic [3:0]  pos4, neg4;

    always #5 clk = ~clk;

    emmc_ddr_tx #(.BUS_WIDTH(8), .BLOCK_SIZE(512)) u_w8 (
        .Clk(clk), .Reset_n(rst_n), .start(start8), .abort(abort),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(rdy8),
        .WriteData_posEdge(pos8), .WriteData_negEdge(neg8),
        .out_en(oe8), .busy(busy8), .done(done8), .underrun(ur8)
    );

    emmc_ddr_tx #(.BUS_WIDTH(4), .BLOCK_SIZE(512)) u_w4 (
        .Clk(clk), .Reset_n(rst_n), .start(start4), .abort(abort),
        .tx_data(tx_data[7:0]), .tx_valid(tx_valid), .tx_ready(rdy4),
        .WriteData_posEdge(pos4), .WriteData_negEdge(neg4),
        .out_en(oe4), .busy(busy4), .done(done4), .underrun(ur4)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {underrun, out_en, busy, tx_ready, done, pos[7:0], neg[7:0]}
    function automatic logic [20:0] obs(input int w);
        if (w == 8) return {ur8, oe8, busy8, rdy8, done8, pos8, neg8};
        return {ur4, oe4, busy4, rdy4, done4, 4'h0, pos4, 4'h0, neg4};
    endfunction

    function automatic logic [20:0] idle_vec(input int w, input logic ur);
        logic [7:0] m;
        m = (w == 8) ? 8'hFF : 8'h0F;
        return {ur, 4'b0000, m, m};
    endfunction

    // Remainder of msg(x) * x^16 divided by x^16+x^12+x^5+1
    function automatic logic [15:0] crc_ref(input bit msg[$]);
        logic [16:0] r;
        r = '0;
        for (int b = 0; b < msg.size() + 16; b++) begin
            r = {r[15:0], (b < msg.size()) ? msg[b] : 1'b0};
            if (r[16]) r = r ^ 17'h11021;
        end
        return r[15:0];
    endfunction

    // p = edges after the start edge at which the outputs are sampled
    task automatic run_block(input int w, input bit zero, input int gap_at, input int gap_len,
                             input int restart_t, input int abort_t, input int rst_t);
        int          n, last, n_acc, n_oe;
        logic [15:0] mask, d;
        logic [7:0]  lmask, ep, en;
        logic [15:0] wd[$], sent[$];
        bit          vld[$], mp[$], mn[$];
        bit          v;
        logic [15:0] crcp[8], crcn[8];
        logic        exo, exb, exr, exd, exu;
        logic [20:0] o;
        n     = 2048 / w;
        mask  = (w == 8) ? 16'hFFFF : 16'h00FF;
        lmask = (w == 8) ? 8'hFF : 8'h0F;
        n_acc = 0;
        n_oe  = 0;
        for (int j = 0; j < n; j++) begin
            d = zero ? 16'h0000 : (16'($urandom) & mask);
            v = !(j >= gap_at && j < gap_at + gap_len);
            wd.push_back(d);
            vld.push_back(v);
            sent.push_back(v ? d : 16'h0000);
        end
        for (int i = 0; i < w; i++) begin
            mp.delete();
            mn.delete();
            foreach (sent[j]) begin
                mp.push_back(sent[j][w + i]);
                mn.push_back(sent[j][i]);
            end
            crcp[i] = crc_ref(mp);
            crcn[i] = crc_ref(mn);
        end

        if (w == 8) start8 = 1'b1; else start4 = 1'b1;
        tx_valid = 1'($urandom);
        tx_data  = 16'($urandom);
        @(posedge clk); #1;
        start8 = 1'b0;
        start4 = 1'b0;
        last = (abort_t >= 0) ? abort_t + 4 : n + 20;

        for (int p = 0; p <= last; p++) begin
            ep = lmask; en = lmask;
            exo = 1'b0; exb = 1'b0; exr = 1'b0; exd = 1'b0;
            exu = (gap_len > 0) && (p >= gap_at + 1);
            if (abort_t >= 0 && p > abort_t) begin
                // aborted: idle values, no done
            end else if (p == 0) begin
                ep = '0; en = '0; exo = 1'b1; exb = 1'b1; exr = 1'b1;
            end else if (p <= n) begin
                ep  = 8'(sent[p-1] >> w) & lmask;
                en  = 8'(sent[p-1]) & lmask;
                exo = 1'b1; exb = 1'b1; exr = (p <= n - 1);
            end else if (p <= n + 16) begin
                for (int i = 0; i < w; i++) begin
                    ep[i] = crcp[i][15 - (p - n - 1)];
                    en[i] = crcn[i][15 - (p - n - 1)];
                end
                exo = 1'b1; exb = 1'b1;
            end else if (p == n + 17) begin
                exo = 1'b1; exb = 1'b1;
            end else if (p == n + 18) begin
                exd = 1'b1;
            end
            o = obs(w);
            chk($sformatf("w%0d frame p%0d", w, p), 32'(o), 32'({exu, exo, exb, exr, exd, ep, en}));
            if (o[19]) n_oe++;

            if (p == rst_t) begin
                #2 rst_n = 1'b0;
                #1 chk($sformatf("w%0d async reset", w), 32'(obs(w)), 32'(idle_vec(w, 1'b0)));
                #3 rst_n = 1'b1;
                @(posedge clk); #1;
                chk($sformatf("w%0d after reset", w), 32'(obs(w)), 32'(idle_vec(w, 1'b0)));
                return;
            end

            abort = (p == abort_t);
            if (p == restart_t) begin
                if (w == 8) start8 = 1'b1; else start4 = 1'b1;
            end else begin
                start8 = 1'b0;
                start4 = 1'b0;
            end
            if (p < n) begin
                tx_valid = vld[p];
                tx_data  = wd[p];
                if (o[17] && vld[p]) n_acc++;
            end else begin
                tx_valid = 1'($urandom);
                tx_data  = 16'($urandom);
            end
            @(posedge clk); #1;
        end
        abort  = 1'b0;
        start8 = 1'b0;
        start4 = 1'b0;
        if (abort_t < 0) begin
            chk($sformatf("w%0d out_en cycles", w), 32'(n_oe), 32'(n + 18));
            chk($sformatf("w%0d words accepted", w), 32'(n_acc), 32'(n - gap_len));
        end
    endtask

    initial begin
        start8 = 1'b0; start4 = 1'b0; abort = 1'b0; tx_valid = 1'b0; tx_data = '0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset w8", 32'(obs(8)), 32'(idle_vec(8, 1'b0)));
        chk("reset w4", 32'(obs(4)), 32'(idle_vec(4, 1'b0)));
        #3 rst_n = 1'b1;
        @(posedge clk); #1;

        run_block(8, 1'b1, -1, 0, -1, -1, -1);      // all-zero block, done at p=274
        run_block(4, 1'b0, -1, 0, -1, -1, -1);      // random 4-bit block
        run_block(8, 1'b0, 100, 3, -1, -1, -1);     // 3-word underrun
        repeat (3) @(posedge clk);
        #1 chk("underrun sticky", 32'(ur8), 32'd1);
        run_block(8, 1'b0, -1, 0, -1, 11, -1);      // abort in DATA cycle 10
        run_block(8, 1'b0, -1, 0, -1, -1, 256 + 5); // reset during CRC
        run_block(8, 1'b0, -1, 0, -1, -1, -1);      // clean block after reset

        // start with abort in IDLE is ignored
        start8 = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0; abort = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("start+abort idle c%0d", c), 32'(obs(8)), 32'(idle_vec(8, 1'b0)));
            @(posedge clk); #1;
        end

        run_block(8, 1'b0, -1, 0, 50, -1, -1);      // start re-pulsed while busy
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("single block c%0d", c), 32'({busy8, oe8}), 32'd0);
            @(posedge clk); #1;
        end
        run_block(4, 1'b0, 200, 3, 10, -1, -1);     // 4-bit underrun + restart ignored

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
